// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation engine: register-file
// selects, compute FSM states and byte-count helpers.
package rsa_pkg;

  localparam logic [1:0] REG_RES  = 2'd0;
  localparam logic [1:0] REG_BASE = 2'd1;
  localparam logic [1:0] REG_EXP  = 2'd2;
  localparam logic [1:0] REG_MOD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SQR,
    S_MUL,
    S_NEXT,
    S_WB
  } state_t;

  // Byte count of the default 256-bit build; parameterised instances use nbytes_of().
  localparam int NBYTES = 256 / 8;

  function automatic int nbytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier, MSB-first over B.
// One load cycle followed by WIDTH step cycles. A, B and N are read live and
// must be held stable by the caller for the whole operation; done is high
// during the final step cycle, and P holds the result after that edge.
module rsa_modmul #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic             done,
  output logic [WIDTH-1:0] P
);

  localparam int JW = $clog2(WIDTH);

  logic [JW-1:0] j;
  logic          busy;

  // P stays below N, so 2P + A < 3N fits in WIDTH+2 bits and two
  // conditional subtractions restore the invariant.
  function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] p,
                                               input logic             b_bit,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] nn;
    nn = {2'b00, n};
    t  = {1'b0, p, 1'b0} + (b_bit ? {2'b00, a} : '0);
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

  assign done = busy && (j == '0);

  // Load clears the partial product; each step consumes one bit of B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      P    <= '0;
      j    <= '0;
      busy <= 1'b0;
    end else if (start) begin
      P    <= '0;
      j    <= JW'(WIDTH - 1);
      busy <= 1'b1;
    end else if (busy) begin
      P <= mm_step(P, B[j], A, N);
      j <= j - 1'b1;
      if (j == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time modular exponentiation R0 = R1^R2 mod R3 behind a byte-wide
// register-file port. Left-to-right square-and-always-multiply; one shared
// modular multiplier serves both the square and the multiply phases.
// Build option: define RSA_ZEROIZE_EN to clear the exponent R2 on writeback.
module rsa_modexp_core import rsa_pkg::*; #(
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              oe,
  input  logic              start,
  input  logic [1:0]        reg_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic              ready,
  output logic              err
);

  localparam int NB = nbytes_of(WIDTH);
  localparam int IW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] rf [4];
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;
  logic             take;
  logic             ld;
  logic             mm_start;
  logic             mm_done;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_p;
  logic             addr_ok;
  logic             mod_zero;

  function automatic logic [7:0] get_byte(input logic [WIDTH-1:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  assign addr_ok  = int'(addr) < NB;
  assign mod_zero = (rf[REG_MOD] == '0);

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .start (mm_start),
    .A     (acc),
    .B     (mm_b),
    .N     (rf[REG_MOD]),
    .done  (mm_done),
    .P     (mm_p)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state: every phase runs to multiplier completion, so timing never depends on data.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start && !mod_zero) state_n = S_INIT;
      S_INIT: state_n = S_SQR;
      S_SQR:  if (mm_done) state_n = S_MUL;
      S_MUL:  if (mm_done) state_n = (idx == '0) ? S_WB : S_SQR;
      S_WB:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs: ready flag, multiplier launch and B operand select.
  always_comb begin
    ready    = 1'b0;
    mm_start = 1'b0;
    mm_b     = acc;
    case (state)
      S_IDLE: ready = 1'b1;
      S_SQR:  mm_start = ld;
      S_MUL:  begin
        mm_start = ld;
        mm_b     = rf[REG_BASE];
      end
      default: ;
    endcase
  end

  // Accumulator and bit index. The previous product is committed on the
  // next phase's load edge; a multiply result is kept only if its exponent
  // bit was set (recorded in take when the multiply finished).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      idx  <= '0;
      take <= 1'b0;
      ld   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          acc  <= WIDTH'(1);
          idx  <= IW'(WIDTH - 1);
          take <= 1'b0;
          ld   <= 1'b1;
        end
        S_SQR: begin
          if (ld) begin
            ld   <= 1'b0;
            take <= 1'b0;
            if (take) acc <= mm_p;
          end else if (mm_done) begin
            ld <= 1'b1;
          end
        end
        S_MUL: begin
          if (ld) begin
            ld  <= 1'b0;
            acc <= mm_p;
          end else if (mm_done) begin
            take <= rf[REG_EXP][idx];
            ld   <= 1'b1;
            if (idx != '0) idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file: host byte writes, error handling on start, writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) rf[k] <= '0;
      err <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        if (mod_zero) begin
          err         <= 1'b1;
          rf[REG_RES] <= '0;
        end else begin
          err <= 1'b0;
        end
      end
      if (!we && ready && addr_ok && reg_sel != REG_RES)
        rf[reg_sel][8*int'(addr) +: 8] <= data_i;
      if (state == S_WB) begin
        rf[REG_RES] <= take ? mm_p : acc;
`ifdef RSA_ZEROIZE_EN
        rf[REG_EXP] <= '0;
`else
        rf[REG_EXP] <= rf[REG_EXP];
`endif
      end
    end
  end

  // Registered read port; sees the pre-write value when read and write coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   data_o <= 8'h00;
    else if (!oe) data_o <= addr_ok ? get_byte(rf[reg_sel], int'(addr)) : 8'h00;
  end

endmodule
